// File: rtl/crossbar_param_if.sv
// Bundles the upstream PHV/action handshake and the downstream ALU-operand
// handshake of the crossbar into one port. The design takes the slave view;
// whatever drives the inputs and consumes the operands takes the master view.
interface crossbar_param_if #(
   parameter int NUM_CONT = 64,
   parameter int CONT_W   = 32,
   parameter int ACT_LEN  = 64,
   parameter int REMAIN_W = 256
);
   localparam int PHV_LEN = NUM_CONT*CONT_W + REMAIN_W;
   localparam int ACT_W   = ACT_LEN*(NUM_CONT+1);
   localparam int DAT_W   = NUM_CONT*CONT_W;

   logic [PHV_LEN-1:0]  phv_in;
   logic                phv_in_valid;
   logic [ACT_W-1:0]    action_in;
   logic                action_in_valid;
   logic                ready_out;
   logic [DAT_W-1:0]    alu_in_1;
   logic [DAT_W-1:0]    alu_in_2;
   logic [DAT_W-1:0]    alu_in_3;
   logic [REMAIN_W-1:0] phv_remain_data;
   logic [ACT_W-1:0]    action_out;
   logic                alu_in_valid;
   logic                ready_in;
   logic                err_idx;
   logic [15:0]         stall_cnt;

   modport slave (
      input  phv_in, phv_in_valid, action_in, action_in_valid, ready_in,
      output ready_out, alu_in_1, alu_in_2, alu_in_3, phv_remain_data,
             action_out, alu_in_valid, err_idx, stall_cnt
   );

   modport master (
      output phv_in, phv_in_valid, action_in, action_in_valid, ready_in,
      input  ready_out, alu_in_1, alu_in_2, alu_in_3, phv_remain_data,
             action_out, alu_in_valid, err_idx, stall_cnt
   );
endinterface

// File: rtl/crossbar_param.sv
// PHV operand crossbar: each container lane decodes its sub-action and picks
// operand A/B from the PHV containers or the immediate. Results land in a
// 2-entry FIFO whose head drives the ALU inputs.

// One lane of operand selection. Purely combinational.
module crossbar_param_lane #(
   parameter int NUM_CONT = 64,
   parameter int CONT_W   = 32,
   parameter int ACT_LEN  = 64,
   parameter int IDX_W    = 6,
   parameter int LANE     = 0
) (
   input  logic [NUM_CONT*CONT_W-1:0] cont,
   input  logic [ACT_LEN-1:0]         sub,
   output logic [CONT_W-1:0]          opa,
   output logic [CONT_W-1:0]          opb,
   output logic [CONT_W-1:0]          opc,
   output logic                       err
);
   logic [7:0]        op;
   logic [IDX_W-1:0]  ia, ib, ia_s, ib_s;
   logic [CONT_W-1:0] imm, own, cont_a, cont_b;
   logic              a_ok, b_ok, use_a, use_b;
   logic              unused_sub;

   // Padding bits between the indices and the immediate carry no meaning.
   assign unused_sub = ^sub;

   assign op  = sub[ACT_LEN-1 -: 8];
   assign ia  = sub[ACT_LEN-9 -: IDX_W];
   assign ib  = sub[ACT_LEN-9-IDX_W -: IDX_W];
   assign imm = sub[CONT_W-1:0];
   assign own = cont[LANE*CONT_W +: CONT_W];

   // Out-of-range indices are steered to 0 so the read never leaves the vector.
   assign a_ok   = int'(ia) < NUM_CONT;
   assign b_ok   = int'(ib) < NUM_CONT;
   assign ia_s   = a_ok ? ia : '0;
   assign ib_s   = b_ok ? ib : '0;
   assign cont_a = cont[int'(ia_s)*CONT_W +: CONT_W];
   assign cont_b = cont[int'(ib_s)*CONT_W +: CONT_W];

   // Opcode decode: which operands come from the PHV, which from the immediate.
   always_comb begin
      use_a = 1'b0;
      use_b = 1'b0;
      opa   = own;
      opb   = '0;
      case (op)
         8'h01, 8'h02, 8'h07, 8'h08, 8'h0B: begin
            use_a = 1'b1;
            use_b = 1'b1;
         end
         8'h09, 8'h0A: begin
            use_a = 1'b1;
            opb   = imm;
         end
         8'h0E: begin
            opa = '0;
            opb = imm;
         end
         default: ;
      endcase
      if (use_a) opa = a_ok ? cont_a : '0;
      if (use_b) opb = b_ok ? cont_b : '0;
      err = (use_a && !a_ok) || (use_b && !b_ok);
   end

   assign opc = own;
endmodule

module crossbar_param #(
   parameter int NUM_CONT = 64,
   parameter int CONT_W   = 32,
   parameter int ACT_LEN  = 64,
   parameter int REMAIN_W = 256
) (
   input logic         clk,
   input logic         rst_n,
   crossbar_param_if.slave bus
);
   localparam int IDX_W   = $clog2(NUM_CONT);
   localparam int PHV_LEN = NUM_CONT*CONT_W + REMAIN_W;
   localparam int DAT_W   = NUM_CONT*CONT_W;
   localparam int ACT_W   = ACT_LEN*(NUM_CONT+1);

   if (CONT_W > ACT_LEN-8-2*IDX_W) begin : g_cfg_bad
      $error("crossbar_param: immediate overlaps index fields (CONT_W too large)");
   end

   typedef struct packed {
      logic [DAT_W-1:0]    a;
      logic [DAT_W-1:0]    b;
      logic [DAT_W-1:0]    c;
      logic [REMAIN_W-1:0] rem;
      logic [ACT_W-1:0]    act;
   } entry_t;

   logic [NUM_CONT-1:0][CONT_W-1:0] lane_a, lane_b, lane_c;
   logic [NUM_CONT-1:0]             lane_err;

   for (genvar i = 0; i < NUM_CONT; i++) begin : g_lane
      crossbar_param_lane #(
         .NUM_CONT(NUM_CONT), .CONT_W(CONT_W), .ACT_LEN(ACT_LEN),
         .IDX_W(IDX_W), .LANE(i)
      ) u_lane (
         .cont (bus.phv_in[PHV_LEN-1:REMAIN_W]),
         .sub  (bus.action_in[(NUM_CONT-i)*ACT_LEN-1 -: ACT_LEN]),
         .opa  (lane_a[i]),
         .opb  (lane_b[i]),
         .opc  (lane_c[i]),
         .err  (lane_err[i])
      );
   end

   entry_t      mem_q [2];
   entry_t      mem_d [2];
   entry_t      new_ent;
   logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [1:0]  count_q, count_d;
   logic        ready_q, ready_d;
   logic        err_q, err_d;
   logic [15:0] stall_q, stall_d;
   logic        push, pop;

   assign new_ent = {lane_a, lane_b, lane_c, bus.phv_in[REMAIN_W-1:0], bus.action_in};
   assign push    = bus.phv_in_valid && bus.action_in_valid && ready_q;
   assign pop     = (count_q != 2'd0) && bus.ready_in;

   // FIFO bookkeeping, sticky index error and backpressure counter.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      stall_d  = stall_q;
      if (push) begin
         mem_d[wr_ptr_q] = new_ent;
         wr_ptr_d        = ~wr_ptr_q;
         err_d           = err_q | (|lane_err);
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      ready_d = (count_d < 2'd2);
      if ((count_q != 2'd0) && !bus.ready_in && (stall_q != 16'hFFFF))
         stall_d = stall_q + 16'd1;
   end

   // State registers; reset clears buffered entries so nothing stale leaks out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) mem_q[k] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         ready_q  <= 1'b1;
         err_q    <= 1'b0;
         stall_q  <= 16'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         stall_q  <= stall_d;
      end
   end

   assign bus.alu_in_1        = mem_q[rd_ptr_q].a;
   assign bus.alu_in_2        = mem_q[rd_ptr_q].b;
   assign bus.alu_in_3        = mem_q[rd_ptr_q].c;
   assign bus.phv_remain_data = mem_q[rd_ptr_q].rem;
   assign bus.action_out      = mem_q[rd_ptr_q].act;
   assign bus.alu_in_valid    = (count_q != 2'd0);
   assign bus.ready_out       = ready_q;
   assign bus.err_idx         = err_q;
   assign bus.stall_cnt       = stall_q;
endmodule

// File: tb/tb_crossbar_param.sv
// Directed bench for crossbar_param with 48 containers, so that indices
// 48..63 are encodable but out of range.
module tb_crossbar_param;
   localparam int NC = 48, CW = 32, AL = 64, RW = 256;
   localparam int DW = NC*CW, PL = DW + RW, AW = AL*(NC+1), EW = 3*DW + RW + AW;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   crossbar_param_if #(.NUM_CONT(NC), .CONT_W(CW), .ACT_LEN(AL), .REMAIN_W(RW)) bus ();
   crossbar_param #(.NUM_CONT(NC), .CONT_W(CW), .ACT_LEN(AL), .REMAIN_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int n_chk = 0;
   int n_fail = 0;
   logic [EW-1:0] obs;
   assign obs = {bus.alu_in_1, bus.alu_in_2, bus.alu_in_3, bus.phv_remain_data, bus.action_out};

   // Container i = {seed, i, A5, i}; metadata is a repeated seed word.
   function automatic logic [PL-1:0] mk_phv(input logic [7:0] seed);
      logic [PL-1:0] p;
      for (int i = 0; i < NC; i++) p[RW+i*CW +: CW] = {seed, 8'(i), 8'hA5, 8'(i)};
      p[RW-1:0] = {8{seed, 24'h5EED00}};
      return p;
   endfunction

   function automatic logic [AL-1:0] mk_sub(input logic [7:0] op, input logic [5:0] ia,
                                            input logic [5:0] ib, input logic [31:0] imm);
      return {op, ia, ib, 12'h000, imm};
   endfunction

   function automatic logic [AW-1:0] put_sub(input logic [AW-1:0] act, input int lane,
                                             input logic [AL-1:0] s);
      act[(NC-lane)*AL-1 -: AL] = s;
      return act;
   endfunction

   // Every lane gets the same sub-action; sub-action 0 holds junk.
   function automatic logic [AW-1:0] mk_act_all(input logic [AL-1:0] s);
      logic [AW-1:0] act;
      act[AW-1 -: AL] = 64'hBAD0_BAD0_BAD0_BAD0;
      for (int i = 0; i < NC; i++) act = put_sub(act, i, s);
      return act;
   endfunction

   // Reference: expected {A, B, C, metadata, action} for one transaction.
   function automatic logic [EW-1:0] model(input logic [PL-1:0] phv, input logic [AW-1:0] act);
      logic [DW-1:0] a, b, c;
      logic [AL-1:0] s;
      logic [31:0]   ca, cb, own;
      int ka, kb;
      for (int i = 0; i < NC; i++) begin
         s   = act[(NC-i)*AL-1 -: AL];
         own = phv[RW+i*CW +: CW];
         ka  = (s[55:50] < NC) ? int'(s[55:50]) : 0;
         kb  = (s[49:44] < NC) ? int'(s[49:44]) : 0;
         ca  = (s[55:50] < NC) ? phv[RW+ka*CW +: CW] : 32'h0;
         cb  = (s[49:44] < NC) ? phv[RW+kb*CW +: CW] : 32'h0;
         c[i*CW +: CW] = own;
         case (s[63:56])
            8'h01, 8'h02, 8'h07, 8'h08, 8'h0B: begin a[i*CW +: CW] = ca;   b[i*CW +: CW] = cb; end
            8'h09, 8'h0A:                      begin a[i*CW +: CW] = ca;   b[i*CW +: CW] = s[31:0]; end
            8'h0E:                             begin a[i*CW +: CW] = 0;    b[i*CW +: CW] = s[31:0]; end
            default:                           begin a[i*CW +: CW] = own;  b[i*CW +: CW] = 0; end
         endcase
      end
      return {a, b, c, phv[RW-1:0], act};
   endfunction

   task automatic drive(input logic [PL-1:0] phv, input logic [AW-1:0] act, input logic v);
      bus.phv_in          = phv;
      bus.action_in       = act;
      bus.phv_in_valid    = v;
      bus.action_in_valid = v;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive('0, '0, 1'b0);
      bus.ready_in = 1'b1;
      step();
      step();
      n_chk++; if (bus.alu_in_valid !== 1'b0) begin n_fail++; $display("FAIL reset valid: got %b want 0", bus.alu_in_valid); end
      n_chk++; if (bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL reset ready_out: got %b want 1", bus.ready_out); end
      n_chk++; if (bus.err_idx !== 1'b0) begin n_fail++; $display("FAIL reset err_idx: got %b want 0", bus.err_idx); end
      n_chk++; if (bus.stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset stall_cnt: got %0d want 0", bus.stall_cnt); end
      n_chk++; if (obs !== '0) begin n_fail++; $display("FAIL reset data: top bits %h want 0", obs[EW-1 -: 128]); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_sel_pair();
      logic [PL-1:0] phv;
      logic [AW-1:0] act;
      logic [EW-1:0] exp;
      phv = mk_phv(8'h01);
      phv[RW+3*CW +: CW] = 32'h11;
      phv[RW+5*CW +: CW] = 32'h22;
      act = mk_act_all(mk_sub(8'h01, 6'd3, 6'd5, 32'h0BAD0BAD));
      exp = model(phv, act);
      bus.ready_in = 1'b1;
      drive(phv, act, 1'b1);
      n_chk++; if (bus.alu_in_valid !== 1'b0) begin n_fail++; $display("FAIL sel_pair early valid: got %b want 0", bus.alu_in_valid); end
      step();
      drive(phv, act, 1'b0);
      n_chk++; if (bus.alu_in_valid !== 1'b1) begin n_fail++; $display("FAIL sel_pair valid: got %b want 1", bus.alu_in_valid); end
      n_chk++; if (bus.alu_in_1 !== {NC{32'h11}}) begin n_fail++; $display("FAIL sel_pair A: slot0 %h want 11", bus.alu_in_1[31:0]); end
      n_chk++; if (bus.alu_in_2 !== {NC{32'h22}}) begin n_fail++; $display("FAIL sel_pair B: slot0 %h want 22", bus.alu_in_2[31:0]); end
      n_chk++; if (bus.alu_in_3 !== phv[PL-1:RW]) begin n_fail++; $display("FAIL sel_pair C: slot0 %h want %h", bus.alu_in_3[31:0], phv[RW +: 32]); end
      n_chk++; if (obs !== exp) begin n_fail++; $display("FAIL sel_pair entry: low %h want %h", obs[127:0], exp[127:0]); end
      step();
      n_chk++; if (bus.alu_in_valid !== 1'b0) begin n_fail++; $display("FAIL sel_pair pop: valid %b want 0", bus.alu_in_valid); end
   endtask

   task automatic test_imm();
      logic [PL-1:0] phv;
      logic [AW-1:0] act;
      logic [EW-1:0] exp;
      phv = mk_phv(8'h02);
      act = '0;
      act[AW-1 -: AL] = 64'hFFFF_FFFF_FFFF_FFFF;
      for (int i = 0; i < NC; i++)
         act = put_sub(act, i, (i % 2 == 0) ? mk_sub(8'h0E, 6'd1, 6'd2, 32'hDEADBEEF)
                                            : mk_sub(8'h00, 6'd3, 6'd4, 32'h12345678));
      act = put_sub(act, 10, mk_sub(8'h09, 6'd7, 6'd0, 32'hCAFEF00D));
      act = put_sub(act, 11, mk_sub(8'h0A, 6'd47, 6'd0, 32'h0));
      act = put_sub(act, 12, mk_sub(8'h0B, 6'd0, 6'd47, 32'h0));
      exp = model(phv, act);
      drive(phv, act, 1'b1);
      step();
      drive(phv, act, 1'b0);
      n_chk++; if (bus.alu_in_1[31:0] !== 32'h0 || bus.alu_in_2[31:0] !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL imm slot0: A=%h B=%h want 0 deadbeef", bus.alu_in_1[31:0], bus.alu_in_2[31:0]); end
      n_chk++; if (bus.alu_in_1[63:32] !== 32'h0201A501 || bus.alu_in_2[63:32] !== 32'h0) begin
         n_fail++; $display("FAIL imm slot1 op00: A=%h B=%h want 0201a501 0", bus.alu_in_1[63:32], bus.alu_in_2[63:32]); end
      n_chk++; if (bus.alu_in_1[11*CW-1 -: CW] !== 32'h0207A507 || bus.alu_in_2[11*CW-1 -: CW] !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL imm slot10 op09: A=%h B=%h want 0207a507 cafef00d", bus.alu_in_1[11*CW-1 -: CW], bus.alu_in_2[11*CW-1 -: CW]); end
      n_chk++; if (bus.alu_in_1[12*CW-1 -: CW] !== 32'h022FA52F) begin
         n_fail++; $display("FAIL imm slot11 idx47: A=%h want 022fa52f", bus.alu_in_1[12*CW-1 -: CW]); end
      n_chk++; if (obs !== exp) begin n_fail++; $display("FAIL imm entry: low %h want %h", obs[127:0], exp[127:0]); end
      n_chk++; if (bus.err_idx !== 1'b0) begin n_fail++; $display("FAIL imm err_idx: got %b want 0", bus.err_idx); end
      step();
   endtask

   task automatic test_err();
      logic [PL-1:0] phv;
      logic [AW-1:0] act;
      phv = mk_phv(8'h03);
      // idxA=50 on an opcode that ignores idxA must not flag.
      act = put_sub(mk_act_all(mk_sub(8'h00, 6'd63, 6'd63, 32'h0)), 7, mk_sub(8'h0E, 6'd50, 6'd0, 32'h77));
      drive(phv, act, 1'b1);
      step();
      n_chk++; if (bus.err_idx !== 1'b0) begin n_fail++; $display("FAIL err unused idx: err_idx %b want 0", bus.err_idx); end
      act = put_sub(mk_act_all(mk_sub(8'h00, 6'd0, 6'd0, 32'h0)), 7, mk_sub(8'h09, 6'd50, 6'd0, 32'h55));
      drive(phv, act, 1'b1);
      step();
      n_chk++; if (bus.alu_in_1[8*CW-1 -: CW] !== 32'h0 || bus.alu_in_2[8*CW-1 -: CW] !== 32'h55) begin
         n_fail++; $display("FAIL err slot7: A=%h B=%h want 0 55", bus.alu_in_1[8*CW-1 -: CW], bus.alu_in_2[8*CW-1 -: CW]); end
      n_chk++; if (bus.err_idx !== 1'b1) begin n_fail++; $display("FAIL err set: err_idx %b want 1", bus.err_idx); end
      act = put_sub(mk_act_all(mk_sub(8'h00, 6'd0, 6'd0, 32'h0)), 3, mk_sub(8'h01, 6'd47, 6'd48, 32'h0));
      drive(phv, act, 1'b1);
      step();
      drive(phv, act, 1'b0);
      n_chk++; if (bus.alu_in_1[4*CW-1 -: CW] !== 32'h032FA52F || bus.alu_in_2[4*CW-1 -: CW] !== 32'h0) begin
         n_fail++; $display("FAIL err slot3 idx48: A=%h B=%h want 032fa52f 0", bus.alu_in_1[4*CW-1 -: CW], bus.alu_in_2[4*CW-1 -: CW]); end
      step();
      n_chk++; if (bus.err_idx !== 1'b1) begin n_fail++; $display("FAIL err sticky: err_idx %b want 1", bus.err_idx); end
   endtask

   task automatic test_back_to_back();
      logic [PL-1:0] p1, p2, p3;
      logic [AW-1:0] a1, a2, a3;
      logic [EW-1:0] e1, e2, e3;
      p1 = mk_phv(8'h31); a1 = mk_act_all(mk_sub(8'h02, 6'd1, 6'd2, 32'h1));
      p2 = mk_phv(8'h32); a2 = mk_act_all(mk_sub(8'h0A, 6'd9, 6'd0, 32'h2));
      p3 = mk_phv(8'h33); a3 = mk_act_all(mk_sub(8'h0E, 6'd0, 6'd0, 32'h3));
      e1 = model(p1, a1); e2 = model(p2, a2); e3 = model(p3, a3);
      bus.ready_in = 1'b0;
      drive(p1, a1, 1'b1);
      step();
      n_chk++; if (bus.ready_out !== 1'b1 || obs !== e1) begin n_fail++; $display("FAIL b2b first: ready_out %b head %h want 1 %h", bus.ready_out, obs[127:0], e1[127:0]); end
      drive(p2, a2, 1'b1);
      step();
      drive(p3, a3, 1'b1);
      n_chk++; if (bus.ready_out !== 1'b0) begin n_fail++; $display("FAIL b2b full: ready_out %b want 0", bus.ready_out); end
      step();
      step();
      n_chk++; if (bus.ready_out !== 1'b0 || obs !== e1) begin n_fail++; $display("FAIL b2b hold: ready_out %b head %h want 0 %h", bus.ready_out, obs[127:0], e1[127:0]); end
      n_chk++; if (bus.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b stall: got %0d want 3", bus.stall_cnt); end
      bus.ready_in = 1'b1;
      step();
      n_chk++; if (bus.alu_in_valid !== 1'b1 || obs !== e2) begin n_fail++; $display("FAIL b2b T2: valid %b head %h want 1 %h", bus.alu_in_valid, obs[127:0], e2[127:0]); end
      step();
      drive(p3, a3, 1'b0);
      n_chk++; if (bus.alu_in_valid !== 1'b1 || obs !== e3) begin n_fail++; $display("FAIL b2b T3: valid %b head %h want 1 %h", bus.alu_in_valid, obs[127:0], e3[127:0]); end
      step();
      n_chk++; if (bus.alu_in_valid !== 1'b0 || bus.stall_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b drain: valid %b stall %0d want 0 3", bus.alu_in_valid, bus.stall_cnt); end
   endtask

   task automatic test_push_pop();
      logic [PL-1:0] p1, p2;
      logic [AW-1:0] a1, a2;
      logic [EW-1:0] e1, e2;
      p1 = mk_phv(8'h41); a1 = mk_act_all(mk_sub(8'h07, 6'd4, 6'd6, 32'h0));
      p2 = mk_phv(8'h42); a2 = mk_act_all(mk_sub(8'h08, 6'd8, 6'd2, 32'h0));
      e1 = model(p1, a1); e2 = model(p2, a2);
      bus.ready_in = 1'b0;
      drive(p1, a1, 1'b1);
      step();
      bus.ready_in = 1'b1;
      drive(p2, a2, 1'b1);
      n_chk++; if (obs !== e1) begin n_fail++; $display("FAIL pushpop head1: %h want %h", obs[127:0], e1[127:0]); end
      step();
      drive(p2, a2, 1'b0);
      n_chk++; if (bus.alu_in_valid !== 1'b1 || bus.ready_out !== 1'b1 || obs !== e2) begin
         n_fail++; $display("FAIL pushpop swap: valid %b ready %b head %h want 1 1 %h", bus.alu_in_valid, bus.ready_out, obs[127:0], e2[127:0]); end
      step();
      n_chk++; if (bus.alu_in_valid !== 1'b0) begin n_fail++; $display("FAIL pushpop empty: valid %b want 0", bus.alu_in_valid); end
   endtask

   task automatic test_reset_mid();
      logic [PL-1:0] p3;
      logic [AW-1:0] a3;
      logic [EW-1:0] e3;
      p3 = mk_phv(8'h53); a3 = mk_act_all(mk_sub(8'h01, 6'd20, 6'd21, 32'h0));
      e3 = model(p3, a3);
      bus.ready_in = 1'b0;
      drive(mk_phv(8'h51), mk_act_all(mk_sub(8'h00, 6'd0, 6'd0, 32'h0)), 1'b1);
      step();
      drive(mk_phv(8'h52), mk_act_all(mk_sub(8'h0E, 6'd0, 6'd0, 32'h9)), 1'b1);
      step();
      drive(p3, a3, 1'b0);
      n_chk++; if (bus.ready_out !== 1'b0 || bus.alu_in_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid fill: ready %b valid %b want 0 1", bus.ready_out, bus.alu_in_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (bus.alu_in_valid !== 1'b0 || bus.ready_out !== 1'b1) begin n_fail++; $display("FAIL rstmid async: valid %b ready %b want 0 1", bus.alu_in_valid, bus.ready_out); end
      n_chk++; if (obs !== '0 || bus.err_idx !== 1'b0 || bus.stall_cnt !== 16'd0) begin
         n_fail++; $display("FAIL rstmid clear: data %h err %b stall %0d want 0 0 0", obs[127:0], bus.err_idx, bus.stall_cnt); end
      step();
      rst_n = 1'b1;
      bus.ready_in = 1'b1;
      step();
      n_chk++; if (bus.alu_in_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid stale: valid %b want 0", bus.alu_in_valid); end
      drive(p3, a3, 1'b1);
      step();
      drive(p3, a3, 1'b0);
      n_chk++; if (bus.alu_in_valid !== 1'b1 || obs !== e3) begin n_fail++; $display("FAIL rstmid first: valid %b head %h want 1 %h", bus.alu_in_valid, obs[127:0], e3[127:0]); end
      step();
      n_chk++; if (bus.alu_in_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid drain: valid %b want 0", bus.alu_in_valid); end
   endtask

   initial begin
      test_reset();
      test_sel_pair();
      test_imm();
      test_err();
      test_back_to_back();
      test_push_pop();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
